regfile_scoreboard: RTL and testbench

- Parametrised register file with an integrated busy-bit scoreboard. It serves the pipelined successor of the single-cycle RV32I core.
- Holds REG_COUNT architectural registers and serves NUM_RD_PORTS combinational reads with optional write-to-read bypass.
- Tracks which registers have an in-flight producer, so the hazard unit can stall on busy operands without re-decoding the pipeline.
- x0 is hardwired to zero and is never busy.

---
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 91 +++++++++
 tb/tb_regfile_scoreboard.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - register file / scoreboard port bundle
//   rd_addr_i/rd_data_o/rd_busy_o : packed combinational read ports
//   wr_en_i/wr_addr_i/wr_data_i   : writeback port (clears busy)
//   alloc_en_i/alloc_addr_i       : issue-stage allocation (sets busy)
//   flush_i                       : clears every busy bit
//   busy_count_o/waw_o            : registered status
interface regfile_scoreboard_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS   = 2
);
  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_RD_PORTS*XLEN-1:0]           rd_data_o;
  logic [NUM_RD_PORTS-1:0]                rd_busy_o;
  logic                                   wr_en_i;
  logic [REG_ADDR_WIDTH-1:0]              wr_addr_i;
  logic [XLEN-1:0]                        wr_data_i;
  logic                                   alloc_en_i;
  logic [REG_ADDR_WIDTH-1:0]              alloc_addr_i;
  logic                                   flush_i;
  logic [REG_ADDR_WIDTH:0]                busy_count_o;
  logic                                   waw_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    output alloc_en_i, alloc_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_count_o, waw_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    input  alloc_en_i, alloc_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_count_o, waw_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with busy-bit scoreboard
//   clk : core clock, rising edge
//   rst : asynchronous active-high reset
//   bus : regfile_scoreboard_if.slave (reads, writeback, allocation, flush, status)
module regfile_scoreboard #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS   = 2,
  parameter int BYPASS         = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int REG_COUNT = 2 ** REG_ADDR_WIDTH;
  localparam int CW        = REG_ADDR_WIDTH + 1;

  logic [XLEN-1:0]      regs_q [REG_COUNT];
  logic [XLEN-1:0]      regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic [CW-1:0]        busy_count_q;
  logic [CW-1:0]        busy_count_d;
  logic                 waw_q;
  logic                 waw_d;

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en_i && (bus.wr_addr_i != '0)) begin
      regs_d[bus.wr_addr_i] = bus.wr_data_i;
    end

    // Allocation is applied after the write-clear so a newly issued
    // producer keeps the register busy; flush overrides both.
    busy_d = busy_q;
    if (bus.flush_i) begin
      busy_d = '0;
    end else begin
      if (bus.wr_en_i) begin
        busy_d[bus.wr_addr_i] = 1'b0;
      end
      if (bus.alloc_en_i) begin
        busy_d[bus.alloc_addr_i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;

    waw_d = bus.alloc_en_i && !bus.flush_i && (bus.alloc_addr_i != '0) &&
            busy_q[bus.alloc_addr_i] &&
            !(bus.wr_en_i && (bus.wr_addr_i == bus.alloc_addr_i));

    busy_count_d = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      busy_count_d = busy_count_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
      waw_q        <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      waw_q        <= waw_d;
    end
  end

  // Read ports: same-cycle allocation is deliberately not forwarded, only
  // writeback data and its busy-clear.
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [REG_ADDR_WIDTH-1:0] rd_a;
    logic                      rd_hit;

    assign rd_a   = bus.rd_addr_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign rd_hit = (BYPASS != 0) && bus.wr_en_i && (bus.wr_addr_i == rd_a);

    assign bus.rd_data_o[p*XLEN +: XLEN] = (rd_a == '0) ? '0 :
                                           rd_hit       ? bus.wr_data_i :
                                                          regs_q[rd_a];
    assign bus.rd_busy_o[p] = busy_q[rd_a] && !rd_hit;
  end

  assign bus.busy_count_o = busy_count_q;
  assign bus.waw_o        = waw_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NP   = 2;
  localparam int RC   = 32;

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d0;
    logic [1:0]  b1;
    logic [1:0]  b0;
    logic [5:0]  cnt;
    logic        waw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]   i_ra0 = '0, i_ra1 = '0, i_wa = '0, i_aa = '0;
  logic [XLEN-1:0] i_wd = '0;
  logic            i_wen = 1'b0, i_aen = 1'b0, i_fl = 1'b0;

  regfile_scoreboard_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)) if_b1 ();
  regfile_scoreboard_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)) if_b0 ();

  assign if_b1.rd_addr_i = {i_ra1, i_ra0};
  assign if_b1.wr_en_i = i_wen;
  assign if_b1.wr_addr_i = i_wa;
  assign if_b1.wr_data_i = i_wd;
  assign if_b1.alloc_en_i = i_aen;
  assign if_b1.alloc_addr_i = i_aa;
  assign if_b1.flush_i = i_fl;
  assign if_b0.rd_addr_i = {i_ra1, i_ra0};
  assign if_b0.wr_en_i = i_wen;
  assign if_b0.wr_addr_i = i_wa;
  assign if_b0.wr_data_i = i_wd;
  assign if_b0.alloc_en_i = i_aen;
  assign if_b0.alloc_addr_i = i_aa;
  assign if_b0.flush_i = i_fl;

  regfile_scoreboard #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_RD_PORTS(NP), .BYPASS(1))
    u_dut_b1 (.clk(clk), .rst(rst), .bus(if_b1));
  regfile_scoreboard #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_RD_PORTS(NP), .BYPASS(0))
    u_dut_b0 (.clk(clk), .rst(rst), .bus(if_b0));

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference state
  logic [XLEN-1:0] m_regs [RC];
  bit              m_busy [RC];
  int              m_cnt;
  bit              m_waw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < RC; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 0;
    end
    m_cnt = 0;
    m_waw = 0;
  endfunction

  // One rising edge's effect given the inputs held across it
  function automatic void model_step();
    bit waw_next;
    waw_next = i_aen && !i_fl && (i_aa != 0) && m_busy[i_aa] && !(i_wen && i_wa == i_aa);
    if (i_wen && i_wa != 0) m_regs[i_wa] = i_wd;
    if (i_fl) begin
      for (int r = 0; r < RC; r++) m_busy[r] = 0;
    end else begin
      if (i_wen) m_busy[i_wa] = 0;
      if (i_aen && i_aa != 0) m_busy[i_aa] = 1;
    end
    m_waw = waw_next;
    m_cnt = 0;
    for (int r = 0; r < RC; r++) m_cnt += int'(m_busy[r]);
  endfunction

  function automatic void push_exp();
    exp_t e;
    logic [AW-1:0] a;
    bit hit;
    for (int p = 0; p < NP; p++) begin
      a   = (p == 0) ? i_ra0 : i_ra1;
      hit = i_wen && (i_wa == a);
      e.d1[p*32 +: 32] = (a == 0) ? 32'h0 : (hit ? i_wd : m_regs[a]);
      e.b1[p]          = m_busy[a] && !hit;
      e.d0[p*32 +: 32] = (a == 0) ? 32'h0 : m_regs[a];
      e.b0[p]          = m_busy[a];
    end
    e.cnt = 6'(m_cnt);
    e.waw = m_waw;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic wen, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic aen, input logic [AW-1:0] aa, input logic fl);
    @(posedge clk);
    #1;
    if (!rst) model_step();
    i_ra0 = ra0; i_ra1 = ra1;
    i_wen = wen; i_wa = wa; i_wd = wd;
    i_aen = aen; i_aa = aa; i_fl = fl;
    push_exp();
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    drive(ra0, ra1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [AW-1:0] pick();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, RC - 1));
  endfunction

  // Monitor: one expected entry per cycle, compared away from the edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd_data_b1", 64'(if_b1.rd_data_o), e.d1);
      chk("rd_busy_b1", 64'(if_b1.rd_busy_o), 64'(e.b1));
      chk("rd_data_b0", 64'(if_b0.rd_data_o), e.d0);
      chk("rd_busy_b0", 64'(if_b0.rd_busy_o), 64'(e.b0));
      chk("busy_count_b1", 64'(if_b1.busy_count_o), 64'(e.cnt));
      chk("busy_count_b0", 64'(if_b0.busy_count_o), 64'(e.cnt));
      chk("waw_b1", 64'(if_b1.waw_o), 64'(e.waw));
      chk("waw_b0", 64'(if_b0.waw_o), 64'(e.waw));
    end
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 64'(if_b1.busy_count_o), 64'd0);
    chk("reset_waw", 64'(if_b1.waw_o), 64'd0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle discards x5 write and allocation
    drive(5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0);
    idle(5'd5, 5'd5);
    #2;
    chk("pre_reset_x5", 64'(if_b1.rd_data_o), {2{32'hDEADBEEF}});
    @(posedge clk);
    #1;
    model_step();
    #2;
    rst = 1'b1;
    model_clear();
    push_exp();
    #1;
    chk("async_reset_data", 64'(if_b1.rd_data_o), 64'd0);
    chk("async_reset_busy", 64'(if_b1.rd_busy_o), 64'd0);
    chk("async_reset_count", 64'(if_b1.busy_count_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp();

    // x0 stays zero
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0);
    #2;
    chk("x0_bypass", 64'(if_b1.rd_data_o), 64'd0);
    idle(5'd0, 5'd0);
    #2;
    chk("x0_after", 64'(if_b1.rd_data_o), 64'd0);
    chk("x0_busy", 64'(if_b1.rd_busy_o), 64'd0);

    // Same-cycle write bypass
    drive(5'd7, 5'd7, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    #2;
    chk("bypass1_now", 64'(if_b1.rd_data_o), {2{32'hCAFEF00D}});
    chk("bypass0_now", 64'(if_b0.rd_data_o), 64'd0);
    idle(5'd7, 5'd7);
    #2;
    chk("bypass1_next", 64'(if_b1.rd_data_o), {2{32'hCAFEF00D}});
    chk("bypass0_next", 64'(if_b0.rd_data_o), {2{32'hCAFEF00D}});

    // Busy tracking of x3
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    #2;
    chk("alloc_c0_busy", 64'(if_b1.rd_busy_o), 64'd0);
    idle(5'd3, 5'd3);
    #2;
    chk("alloc_c1_busy", 64'(if_b1.rd_busy_o), 64'd3);
    chk("alloc_c1_count", 64'(if_b1.busy_count_o), 64'd1);
    idle(5'd3, 5'd3);
    idle(5'd3, 5'd3);
    drive(5'd3, 5'd3, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 1'b0);
    #2;
    chk("wr_c4_busy_b1", 64'(if_b1.rd_busy_o), 64'd0);
    chk("wr_c4_busy_b0", 64'(if_b0.rd_busy_o), 64'd3);
    idle(5'd3, 5'd3);
    #2;
    chk("wr_c5_busy", 64'(if_b1.rd_busy_o), 64'd0);
    chk("wr_c5_count", 64'(if_b1.busy_count_o), 64'd0);

    // Simultaneous alloc and write on x9, then a true WAW
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    drive(5'd9, 5'd9, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0);
    idle(5'd9, 5'd9);
    #2;
    chk("aw_busy", 64'(if_b1.rd_busy_o), 64'd3);
    chk("aw_data", 64'(if_b1.rd_data_o), {2{32'h55}});
    chk("aw_waw", 64'(if_b1.waw_o), 64'd0);
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    idle(5'd9, 5'd9);
    #2;
    chk("waw_pulse", 64'(if_b1.waw_o), 64'd1);
    idle(5'd9, 5'd9);
    #2;
    chk("waw_single", 64'(if_b1.waw_o), 64'd0);

    // Flush with concurrent alloc and write
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    drive(5'd1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    drive(5'd1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    drive(5'd1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b0);
    idle(5'd1, 5'd4);
    #2;
    chk("pre_flush_count", 64'(if_b1.busy_count_o), 64'd3);
    drive(5'd1, 5'd4, 1'b1, 5'd1, 32'h77, 1'b1, 5'd4, 1'b1);
    idle(5'd1, 5'd4);
    #2;
    chk("flush_count", 64'(if_b1.busy_count_o), 64'd0);
    chk("flush_waw", 64'(if_b1.waw_o), 64'd0);
    chk("flush_busy", 64'(if_b1.rd_busy_o), 64'd0);
    chk("flush_data", 64'(if_b1.rd_data_o), {32'h0, 32'h77});

    // Random stress
    for (int i = 0; i < 10000; i++) begin
      logic [AW-1:0] wa;
      logic          wen;
      wa  = pick();
      wen = ($urandom_range(0, 1) == 1);
      drive(($urandom_range(0, 3) == 0) ? wa : pick(), pick(),
            wen, wa, $urandom, ($urandom_range(0, 1) == 1), pick(),
            ($urandom_range(0, 19) == 0));
    end

    idle(5'd0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
